// File: rtl/fifo_stream_reader_if.sv
// Read-side handshake bundle between the async FIFO read port, the
// fifo_stream_reader and its downstream valid/ready consumer.
interface fifo_stream_reader_if #(
    parameter int unsigned dataWidth  = 8,
    parameter int unsigned countWidth = 16
);
    logic                  enableIn;
    logic                  fifoEmptyIn;
    logic [dataWidth-1:0]  fifoDataIn;
    logic                  fifoReadEnableOut;
    logic [dataWidth-1:0]  streamDataOut;
    logic                  streamValidOut;
    logic                  streamReadyIn;
    logic                  streamLastOut;
    logic [countWidth-1:0] wordCountOut;

    modport slave (
        input  enableIn,
        input  fifoEmptyIn,
        input  fifoDataIn,
        input  streamReadyIn,
        output fifoReadEnableOut,
        output streamDataOut,
        output streamValidOut,
        output streamLastOut,
        output wordCountOut
    );

    modport master (
        output enableIn,
        output fifoEmptyIn,
        output fifoDataIn,
        output streamReadyIn,
        input  fifoReadEnableOut,
        input  streamDataOut,
        input  streamValidOut,
        input  streamLastOut,
        input  wordCountOut
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops the async FIFO read port, absorbs its one-cycle read latency in a
// 4-entry skid buffer and emits a framed valid/ready stream with beat count.
module fifo_stream_reader #(
    parameter int unsigned dataWidth  = 8,
    parameter int unsigned pktLen     = 4,
    parameter int unsigned countWidth = 16
) (
    input logic                 readClkIn,
    input logic                 readRstIn,
    fifo_stream_reader_if.slave bus
);
    localparam int unsigned BEAT_W = (pktLen > 1) ? $clog2(pktLen) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(pktLen - 1);

    logic [dataWidth-1:0]  mem_q [4];
    logic [dataWidth-1:0]  mem_d [4];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [countWidth-1:0] count_q, count_d;

    logic pop;
    logic valid;
    logic xfer;

    always_comb begin
        valid = (occ_q != 3'd0);
        xfer  = valid && bus.streamReadyIn;
        // Reserve a slot for the in-flight word so the buffer can never overflow.
        pop   = readRstIn && bus.enableIn && !bus.fifoEmptyIn &&
                (({1'b0, occ_q} + {3'b000, inflight_q}) < 4'd4);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = pop;
        beat_d     = beat_q;
        count_d    = count_q;

        if (inflight_q) begin
            mem_d[wr_ptr_q] = bus.fifoDataIn;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end

        occ_d = occ_q + {2'b00, inflight_q} - {2'b00, xfer};

        if (xfer) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            count_d  = count_q + countWidth'(1);
            beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge readClkIn or negedge readRstIn) begin
        if (!readRstIn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            count_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            count_q    <= count_d;
        end
    end

    assign bus.fifoReadEnableOut = pop;
    assign bus.streamValidOut    = valid;
    assign bus.streamDataOut     = mem_q[rd_ptr_q];
    assign bus.streamLastOut     = valid && (beat_q == LAST_BEAT);
    assign bus.wordCountOut      = count_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the
// DUT, expected beats are queued at push time and a monitor checks transfers.
module tb_fifo_stream_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.dataWidth(DW), .countWidth(CW)) bus ();

    fifo_stream_reader #(
        .dataWidth (DW),
        .pktLen    (PL),
        .countWidth(CW)
    ) dut (
        .readClkIn(clk),
        .readRstIn(rst_n),
        .bus      (bus)
    );

    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int unsigned   n_pass = 0;
    int unsigned   n_total = 0;
    int unsigned   pops_total;
    int unsigned   exp_idx;
    int unsigned   delivered;
    logic          force_empty;
    logic          last_pop, last_valid, last_last;
    logic [DW-1:0] last_data;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endfunction

    // Every word pushed into the FIFO model is a future beat, in order.
    function automatic void push(logic [DW-1:0] val);
        exp_t e;
        e.data = val;
        e.last = ((exp_idx % PL) == PL - 1);
        fifo_q.push_back(val);
        exp_q.push_back(e);
        exp_idx++;
    endfunction

    function automatic void upd_empty();
        bus.fifoEmptyIn = force_empty || (fifo_q.size() == 0);
    endfunction

    // One clock: sample at negedge, then model the FIFO read latency after the edge.
    task automatic tick();
        upd_empty();
        @(negedge clk);
        last_pop   = bus.fifoReadEnableOut;
        last_valid = bus.streamValidOut;
        last_data  = bus.streamDataOut;
        last_last  = bus.streamLastOut;
        @(posedge clk);
        #1;
        if (last_pop && rst_n) begin
            if (fifo_q.size() != 0) bus.fifoDataIn = fifo_q.pop_front();
            pops_total++;
        end
        upd_empty();
    endtask

    task automatic drain(int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_complete", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pop on every transfer, plus protocol checks.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        exp_t          e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        delivered  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                delivered  = 0;
                prev_stall = 1'b0;
            end else begin
                if (bus.fifoReadEnableOut) begin
                    check("pop_while_empty", bus.fifoEmptyIn, 0);
                    check("occupancy_limit", (pops_total - delivered) < 4, 1);
                end
                if (prev_stall && bus.streamValidOut) begin
                    check("hold_data", bus.streamDataOut, prev_data);
                    check("hold_last", bus.streamLastOut, prev_last);
                end
                if (bus.streamValidOut && bus.streamReadyIn) begin
                    check("word_count", bus.wordCountOut, delivered % (1 << CW));
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", bus.streamDataOut, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", bus.streamDataOut, e.data);
                        check("beat_last", bus.streamLastOut, e.last);
                    end
                    delivered++;
                end
                prev_stall = bus.streamValidOut && !bus.streamReadyIn;
                prev_data  = bus.streamDataOut;
                prev_last  = bus.streamLastOut;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        any_pop;
        int unsigned p0, d0, k, streak;

        rst_n             = 1'b0;
        bus.enableIn      = 1'b1;
        bus.streamReadyIn = 1'b1;
        bus.fifoDataIn    = '0;
        force_empty       = 1'b0;
        pops_total        = 0;
        exp_idx           = 0;
        upd_empty();

        // Reset with an empty FIFO
        tick();
        check("rst_valid", bus.streamValidOut, 0);
        check("rst_last", bus.streamLastOut, 0);
        check("rst_data", bus.streamDataOut, 0);
        check("rst_pop", bus.fifoReadEnableOut, 0);
        tick();
        rst_n   = 1'b1;
        any_pop = 1'b0;
        repeat (5) begin
            tick();
            any_pop = any_pop | last_pop;
        end
        check("empty_no_pop", any_pop, 0);
        check("empty_valid", bus.streamValidOut, 0);
        check("empty_count", bus.wordCountOut, 0);

        // Streaming 0..9
        for (int i = 0; i < 10; i++) push(DW'(i));
        tick();
        check("lat_first_pop", last_pop, 1);
        check("lat_valid_edge1", last_valid, 0);
        tick();
        check("lat_valid_edge2", last_valid, 0);
        streak = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_valid) streak++;
        end
        check("stream_consecutive", streak, 10);
        repeat (3) tick();
        check("stream_count", bus.wordCountOut, 10);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure with 12 words waiting
        bus.streamReadyIn = 1'b0;
        p0 = pops_total;
        for (int i = 0; i < 12; i++) push(DW'(100 + i));
        repeat (8) tick();
        check("bp_pops", pops_total - p0, 4);
        check("bp_pop_stopped", last_pop, 0);
        check("bp_valid", last_valid, 1);
        check("bp_head_data", last_data, 100);
        bus.streamReadyIn = 1'b1;
        drain(60);
        check("bp_total_pops", pops_total - p0, 12);
        check("bp_count", bus.wordCountOut, 22);

        // Enable dropped while a pop is in flight
        p0 = pops_total;
        d0 = delivered;
        for (int i = 0; i < 3; i++) push(DW'(200 + i));
        tick();
        check("en_pop_issued", last_pop, 1);
        bus.enableIn = 1'b0;
        repeat (6) tick();
        check("en_single_pop", pops_total - p0, 1);
        check("en_no_pop", last_pop, 0);
        check("en_inflight_delivered", delivered - d0, 1);
        bus.enableIn = 1'b1;
        drain(40);
        check("en_resume_pops", pops_total - p0, 3);

        // Empty flag toggling every cycle, random ready
        for (int i = 0; i < 30; i++) push(DW'($urandom));
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            force_empty       = ~force_empty;
            bus.streamReadyIn = 1'($urandom_range(0, 1));
            tick();
        end
        force_empty       = 1'b0;
        bus.streamReadyIn = 1'b1;
        check("toggle_drained", exp_q.size(), 0);

        // Mid-packet reset: bring the stream to just after beat 2, then buffer more
        k = (PL - 1 + PL - (exp_idx % PL)) % PL;
        for (int unsigned i = 0; i < k; i++) push(DW'(30 + i));
        drain(40);
        bus.streamReadyIn = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'(40 + i));
        repeat (4) tick();
        check("mid_buffered", last_valid, 1);
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        exp_idx    = 0;
        pops_total = 0;
        #1;
        check("mid_rst_valid", bus.streamValidOut, 0);
        check("mid_rst_last", bus.streamLastOut, 0);
        check("mid_rst_data", bus.streamDataOut, 0);
        check("mid_rst_count", bus.wordCountOut, 0);
        check("mid_rst_pop", bus.fifoReadEnableOut, 0);
        tick();
        tick();
        rst_n             = 1'b1;
        bus.streamReadyIn = 1'b1;
        for (int i = 0; i < 4; i++) push(DW'(50 + i));
        drain(40);
        check("mid_count", bus.wordCountOut, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for the team's asynchronous FIFO, running entirely in the FIFO read clock domain. It pops words from the FIFO read port using pessimistic empty-flag handling. It absorbs the FIFO's one-cycle read latency in a 4-entry skid buffer and presents the data as a valid/ready stream. The stream carries packet framing (`last` every `pktLen` beats) and a running beat count.

## Interface
- `dataWidth`, 8: word width; must match the FIFO `dataWidth`.
- `pktLen`, 4: beats per packet; legal range ≥ 1.
- `countWidth`, 16: width of `wordCountOut`.

- `readClkIn`  in  1  read-domain clock; all logic on rising edge.
- `readRstIn`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `enableIn`  in  1  1 = issue new FIFO pops; 0 = stop popping (buffered and in-flight words still delivered).
- `fifoEmptyIn`  in  1  FIFO `fifoEmptyOut`.
- `fifoDataIn`  in  dataWidth  FIFO `dataOut`; valid in the cycle after a pop edge.
- `fifoReadEnableOut`  out  1  FIFO `readEnableIn` (pop request).
- `streamDataOut`  out  dataWidth  head word of the skid buffer.
- `streamValidOut`  out  1  head word present.
- `streamReadyIn`  in  1  downstream accepts the word; a beat transfers when `streamValidOut && streamReadyIn` at an edge.
- `streamLastOut`  out  1  head word is the final beat of a packet.
- `wordCountOut`  out  countWidth  total beats transferred since reset, wrapping modulo 2^countWidth.

## Operation
- **Skid buffer**
  - 4 entries; 2-bit write and read pointers with natural wrap.
  - 3-bit occupancy `occ`.
  - 1-bit `inflight` register, set on the edge a pop is issued.
- **Pop condition (combinational)**
  - `fifoReadEnableOut = readRstIn && enableIn && !fifoEmptyIn && (occ + inflight < 4)`.
  - The pop condition does not depend on `streamReadyIn`.
- **Capture:** when `inflight == 1`, `fifoDataIn` is written at the write pointer on that edge. The write pointer advances and `inflight` takes the current pop value.
- **Occupancy update:** `occ_next = occ + inflight - (streamValidOut && streamReadyIn)`. Simultaneous capture and transfer leaves `occ` unchanged.
- **Output side**
  - `streamValidOut = (occ != 0)`.
  - `streamDataOut` = entry at the read pointer.
  - The read pointer advances on each transfer.
- **Hold rule:** while `streamValidOut && !streamReadyIn`, `streamDataOut` and `streamLastOut` hold stable.
- **Framing**
  - Beat counter `beat` counts 0..pktLen-1 and advances on each transfer, wrapping to 0 after pktLen-1.
  - `streamLastOut = streamValidOut && (beat == pktLen-1)`.
  - With `pktLen = 1`, `streamLastOut` equals `streamValidOut`.
- **Word count:** `wordCountOut` increments by 1 on each transfer, wrapping from all-ones to 0.
- **Enable:** deasserting `enableIn` takes effect combinationally on the same cycle. A word already in flight is still captured; buffered words still drain.
- **Overflow:** impossible by construction, because `occ + inflight ≤ 4` always holds.
- **Underflow:** a pop is never issued while `fifoEmptyIn = 1`.

## Timing
- **Reset** (`readRstIn = 0`, asynchronous):
  - `occ`, `inflight`, both pointers, `beat`, `wordCountOut` and all buffer entries go to 0.
  - Outputs: `streamValidOut = 0`, `streamLastOut = 0`, `streamDataOut = 0`, `fifoReadEnableOut = 0`.
  - Reset mid-packet discards buffered and in-flight words. After release, framing restarts at beat 0.
- **Release:** first pop possible at the first edge after `readRstIn` rises.
- **Latency:** pop at edge N, then capture at edge N+1, then `streamValidOut = 1` after edge N+1. Empty-deasserted to first valid takes 2 edges.
- **Throughput:** one beat per cycle sustained, given the FIFO stays non-empty and `streamReadyIn = 1`.
- **Backpressure:** with `streamReadyIn = 0`, at most 4 words are buffered. Pops stop when `occ + inflight = 4`. When ready returns, pops resume in the same cycle the sum drops below 4.

## Test plan
- **Reset and empty FIFO.** Stimulus: hold reset 2 cycles, release with `fifoEmptyIn = 1`, `enableIn = 1`. Required: all outputs 0, no pop ever issued, `wordCountOut = 0`.
- **Streaming.** Stimulus: FIFO model supplies 0..9 with 1-cycle read latency, `streamReadyIn = 1`. Required:
  - Beats 0..9 arrive in order on consecutive cycles after the 2-cycle latency.
  - `streamLastOut` is high on values 3 and 7.
  - `wordCountOut = 10`.
- **Backpressure.** Stimulus: `streamReadyIn = 0` with 12 words available. Required:
  - Exactly 4 pops, then `fifoReadEnableOut = 0`.
  - Data 0 is held stable.
  - After ready = 1, words 0..11 are delivered with none lost or duplicated.
- **Enable toggle.** Stimulus: drop `enableIn` in the same cycle a pop is in flight. Required: that word is still delivered; no further pops occur until `enableIn = 1`.
- **Empty boundary.** Stimulus: `fifoEmptyIn` toggles every cycle with random ready. Required:
  - No pop is issued while empty.
  - Output order is preserved.
  - `occ` never exceeds 4.
- **Mid-packet reset.** Stimulus: assert reset after beat 2 of a packet, then stream 4 words. Required: outputs clear immediately; the next `streamLastOut` falls on the 4th beat after reset.
